// File: rtl/comb_diff_pkg.sv
// Shared constants for the comb_diff differentiator and its delay line.
// Build option: COMB_DIFF_SAT_EN selects saturating subtraction in comb_diff.
package comb_diff_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DELAY = 1;
  localparam int MAX_DELAY     = 16;
  // Wide enough to hold every count 0..MAX_DELAY
  localparam int CNT_W         = $clog2(MAX_DELAY + 1);

endpackage

// File: rtl/comb_diff_delay_line.sv
// M-stage shift register: advances only when shift_en=1, clears to zero on reset.
// q presents the sample accepted DELAY shifts ago.
module delay_line
  import comb_diff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DELAY = DEFAULT_DELAY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DELAY-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else if (shift_en) begin
      stage_q[0] <= d;
      for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DELAY-1];

endmodule

// File: rtl/comb_diff.sv
// Comb stage y[n] = x[n] - x[n-M] over accepted samples, 1-cycle registered latency.
// Define COMB_DIFF_SAT_EN to saturate on signed overflow instead of wrapping.
module comb_diff
  import comb_diff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DELAY = DEFAULT_DELAY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] x_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y_out,
  output logic             out_valid,
  output logic             primed
);

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);

  logic [WIDTH-1:0] x_old;
  logic [WIDTH-1:0] y_d, y_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  delay_line #(
    .WIDTH(WIDTH),
    .DELAY(DELAY)
  ) u_delay_line (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (in_valid),
    .d        (x_in),
    .q        (x_old)
  );

`ifdef COMB_DIFF_SAT_EN
  // One guard bit exposes overflow: it disagrees with the result sign only then
  logic [WIDTH:0] diff_full;
  assign diff_full = {x_in[WIDTH-1], x_in} - {x_old[WIDTH-1], x_old};

  always_comb begin
    y_d = diff_full[WIDTH-1:0];
    if (diff_full[WIDTH] != diff_full[WIDTH-1])
      y_d = diff_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  // Modulo 2^WIDTH: exact inverse of a wrapping accumulator
  assign y_d = x_in - x_old;
`endif

  assign cnt_d = (in_valid && cnt_q != DELAY_C) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= in_valid;
      cnt_q <= cnt_d;
      if (in_valid) y_q <= y_d;
    end
  end

  assign y_out     = y_q;
  assign out_valid = vld_q;
  assign primed    = (cnt_q == DELAY_C);

endmodule

// File: tb/tb_comb_diff.sv
// Self-checking bench: three comb_diff instances (M=1,2,4) on shared stimulus,
// a history-queue reference model checked every cycle, plus directed literal checks.
module tb_comb_diff;

  localparam int N = 3;

  function automatic int dly(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] x_in     = 8'd0;
  logic [7:0] y_o [N];
  logic       v_o [N];
  logic       p_o [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    comb_diff #(.WIDTH(8), .DELAY(dly(g))) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .x_in      (x_in),
      .in_valid  (in_valid),
      .y_out     (y_o[g]),
      .out_valid (v_o[g]),
      .primed    (p_o[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every accepted sample since reset, oldest first
  int         hist [$];
  logic [7:0] m_y [N];
  logic       m_v [N];
  logic       m_p [N];
  int         m_n;
  int         m_old;

  initial for (int g = 0; g < N; g++) begin
    m_y[g] = 8'd0; m_v[g] = 1'b0; m_p[g] = 1'b0;
  end

  function automatic logic [7:0] ref_diff(input int a, input int b);
    int d;
    d = a - b;
`ifdef COMB_DIFF_SAT_EN
    if (d > 127)  d = 127;
    if (d < -128) d = -128;
`endif
    return d[7:0];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      for (int g = 0; g < N; g++) begin
        m_y[g] = 8'd0; m_v[g] = 1'b0; m_p[g] = 1'b0;
      end
    end else begin
      if (in_valid) hist.push_back(int'($signed(x_in)));
      m_n = hist.size();
      for (int g = 0; g < N; g++) begin
        m_v[g] = in_valid;
        if (in_valid) begin
          m_old = (m_n > dly(g)) ? hist[m_n-1-dly(g)] : 0;
          m_y[g] = ref_diff(hist[m_n-1], m_old);
        end
        m_p[g] = (m_n >= dly(g));
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      chk($sformatf("model_y[%0d]", g), 32'(y_o[g]), 32'(m_y[g]));
      chk($sformatf("model_valid[%0d]", g), 32'(v_o[g]), 32'(m_v[g]));
      chk($sformatf("model_primed[%0d]", g), 32'(p_o[g]), 32'(m_p[g]));
    end
  end

  task automatic drive(input logic [7:0] x, input logic v);
    x_in = x; in_valid = v;
    @(posedge clk); #1;
  endtask

  // Holds a valid sample on the input while in reset; it must be ignored
  task automatic do_reset();
    reset_n = 1'b0; x_in = 8'd99; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0; x_in = 8'd0;
  endtask

  logic [7:0] acc;
  logic [7:0] s;
  int         acc_n;

  initial begin
    do_reset();
    for (int g = 0; g < N; g++) begin
      chk("reset_y", 32'(y_o[g]), 32'd0);
      chk("reset_valid", 32'(v_o[g]), 32'd0);
      chk("reset_primed", 32'(p_o[g]), 32'd0);
    end

    // Basic difference, M=1
    drive(8'd10, 1'b1);
    chk("basic_y0", 32'(y_o[0]), 32'd10);
    chk("basic_v0", 32'(v_o[0]), 32'd1);
    chk("basic_primed0", 32'(p_o[0]), 32'd1);
    drive(8'd30, 1'b1);
    chk("basic_y1", 32'(y_o[0]), 32'd20);
    drive(8'd25, 1'b1);
    chk("basic_y2", 32'(y_o[0]), 32'hFB);
    chk("basic_v2", 32'(v_o[0]), 32'd1);
    drive(8'd77, 1'b0);
    chk("basic_idle_v", 32'(v_o[0]), 32'd0);
    chk("basic_idle_hold", 32'(y_o[0]), 32'hFB);

    // Wrap / saturate, M=1
    do_reset();
    drive(8'd1, 1'b1);
    chk("wrap_y0", 32'(y_o[0]), 32'd1);
    drive(8'h80, 1'b1);
`ifdef COMB_DIFF_SAT_EN
    chk("sat_y1", 32'(y_o[0]), 32'h80);
`else
    chk("wrap_y1", 32'(y_o[0]), 32'h7F);
`endif

    // Gaps, M=2
    do_reset();
    drive(8'd5, 1'b1);
    chk("gap_y0", 32'(y_o[1]), 32'd5);
    chk("gap_primed0", 32'(p_o[1]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(8'h55, 1'b0);
      chk("gap_idle_v", 32'(v_o[1]), 32'd0);
      chk("gap_idle_hold", 32'(y_o[1]), 32'd5);
    end
    drive(8'd7, 1'b1);
    chk("gap_y1", 32'(y_o[1]), 32'd7);
    chk("gap_primed1", 32'(p_o[1]), 32'd1);
    drive(8'd9, 1'b1);
    chk("gap_y2", 32'(y_o[1]), 32'd4);

    // Mid-stream asynchronous reset, M=2
    do_reset();
    drive(8'd40, 1'b1);
    drive(8'd50, 1'b1);
    chk("mrst_pre_y", 32'(y_o[1]), 32'd50);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_y", 32'(y_o[1]), 32'd0);
    chk("mrst_v", 32'(v_o[1]), 32'd0);
    chk("mrst_primed", 32'(p_o[1]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(8'd60, 1'b1);
    chk("mrst_post_y", 32'(y_o[1]), 32'd60);
    chk("mrst_post_v", 32'(v_o[1]), 32'd1);
    chk("mrst_post_primed", 32'(p_o[1]), 32'd0);

    // Accumulator -> comb inverse, with random idle gaps; M=4 priming pinned
    do_reset();
    acc   = 8'd0;
    acc_n = 0;
    while (acc_n < 200) begin
      if ($urandom_range(0, 3) != 0) begin
        s   = 8'($urandom);
        acc = acc + s;
        drive(acc, 1'b1);
        acc_n++;
`ifndef COMB_DIFF_SAT_EN
        chk("inverse_y", 32'(y_o[0]), 32'(s));
`endif
        if (acc_n == 3) chk("prime4_before", 32'(p_o[2]), 32'd0);
        if (acc_n == 4) chk("prime4_after", 32'(p_o[2]), 32'd1);
      end else begin
        drive(8'($urandom), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
